// File: rtl/calc_pkg.sv
// Shared definitions for the calculator controller: key codes, ALU op and FSM state encodings.
// Optional chained-operation support in calc_controller is enabled with CALC_CHAIN_EN.
package calc_pkg;

  localparam logic [4:0] KEY_AC  = 5'b10000;
  localparam logic [4:0] KEY_ADD = 5'b10001;
  localparam logic [4:0] KEY_SUB = 5'b10010;
  localparam logic [4:0] KEY_MUL = 5'b10011;
  localparam logic [4:0] KEY_DIV = 5'b10100;
  localparam logic [4:0] KEY_EQ  = 5'b10101;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_MUL = 2'b10,
    ALU_DIV = 2'b11
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_ENTER_A     = 3'd0,
    ST_ENTER_B     = 3'd1,
    ST_ALU_REQ     = 3'd2,
    ST_ALU_WAIT    = 3'd3,
    ST_SHOW_RESULT = 3'd4,
    ST_ERROR       = 3'd5
  } ctrl_state_e;

  function automatic logic key_is_digit(input logic [4:0] key);
    return (key[4] == 1'b0);
  endfunction

  function automatic logic key_is_op(input logic [4:0] key);
    return (key >= KEY_ADD) && (key <= KEY_DIV);
  endfunction

  function automatic alu_op_e key_to_alu_op(input logic [4:0] key);
    alu_op_e op;
    case (key)
      KEY_ADD: op = ALU_ADD;
      KEY_SUB: op = ALU_SUB;
      KEY_MUL: op = ALU_MUL;
      KEY_DIV: op = ALU_DIV;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/calc_operand_reg.sv
// WIDTH-bit operand register with hex-digit shift-in, parallel load and clear.
// A digit is silently dropped once the top nibble is occupied, so no digits are lost off the top.
module calc_operand_reg
  import calc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic             i_shift,
  input  logic [3:0]       i_digit,
  output logic [WIDTH-1:0] o_value,
  output logic [WIDTH-1:0] o_next
);

  logic [WIDTH-1:0] r_value;
  logic [WIDTH-1:0] w_next;
  logic             w_room;

  assign w_room = (r_value[WIDTH-1:WIDTH-4] == 4'd0);

  // next-value selection: clear beats load beats shift
  always_comb begin
    w_next = r_value;
    if (i_clear) begin
      w_next = '0;
    end else if (i_load) begin
      w_next = i_load_value;
    end else if (i_shift && w_room) begin
      w_next = {r_value[WIDTH-5:0], i_digit};
    end else begin
      w_next = r_value;
    end
  end

  // operand storage
  always_ff @(posedge clk) begin
    if (rst) begin
      r_value <= '0;
    end else begin
      r_value <= w_next;
    end
  end

  assign o_value = r_value;
  assign o_next  = w_next;

endmodule

// File: rtl/calc_controller.sv
// Calculator sequencer: key entry, ALU request/response handshake and display drive.
// Define CALC_CHAIN_EN to let an operator key after a second operand launch the pending op.
module calc_controller
  import calc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       i_key_data,
  input  logic             i_key_valid,
  output logic             o_key_ready,
  output logic             o_alu_valid,
  input  logic             i_alu_ready,
  output logic [1:0]       o_alu_op,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  input  logic             i_alu_result_valid,
  input  logic [WIDTH-1:0] i_alu_result,
  input  logic             i_alu_error,
  output logic [WIDTH-1:0] o_display_value,
  output logic             o_display_error,
  output logic             o_busy
);

  ctrl_state_e      r_state, w_state_nxt;
  alu_op_e          r_op_pend, w_op_pend_nxt;
  logic             r_b_entered, w_b_entered_nxt;
  logic             r_key_ready, r_alu_valid, r_display_error, r_busy;
  logic [WIDTH-1:0] r_display_value, w_display_nxt;

  logic             w_a_clear, w_a_load, w_a_shift, w_b_clear, w_b_shift;
  logic [WIDTH-1:0] w_a_load_val, w_reg_a, w_reg_b, w_a_next, w_b_next;

  logic             w_key_fire, w_is_digit, w_is_op, w_is_eq, w_is_ac;
  alu_op_e          w_key_op;
  logic [3:0]       w_digit;

`ifdef CALC_CHAIN_EN
  alu_op_e          r_op_next, w_op_next_nxt;
  logic             r_chain, w_chain_nxt;
`endif

  assign w_key_fire = i_key_valid && r_key_ready;
  assign w_is_digit = key_is_digit(i_key_data);
  assign w_is_op    = key_is_op(i_key_data);
  assign w_is_eq    = (i_key_data == KEY_EQ);
  assign w_is_ac    = (i_key_data == KEY_AC);
  assign w_key_op   = key_to_alu_op(i_key_data);
  assign w_digit    = i_key_data[3:0];

  calc_operand_reg #(.WIDTH(WIDTH)) u_reg_a (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_a_clear),
    .i_load       (w_a_load),
    .i_load_value (w_a_load_val),
    .i_shift      (w_a_shift),
    .i_digit      (w_digit),
    .o_value      (w_reg_a),
    .o_next       (w_a_next)
  );

  calc_operand_reg #(.WIDTH(WIDTH)) u_reg_b (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_b_clear),
    .i_load       (1'b0),
    .i_load_value ({WIDTH{1'b0}}),
    .i_shift      (w_b_shift),
    .i_digit      (w_digit),
    .o_value      (w_reg_b),
    .o_next       (w_b_next)
  );

  // next-state and register-control decode; AC is only ever consumed in key-accepting states
  always_comb begin
    w_state_nxt     = r_state;
    w_op_pend_nxt   = r_op_pend;
    w_b_entered_nxt = r_b_entered;
    w_a_clear       = 1'b0;
    w_a_load        = 1'b0;
    w_a_load_val    = '0;
    w_a_shift       = 1'b0;
    w_b_clear       = 1'b0;
    w_b_shift       = 1'b0;
`ifdef CALC_CHAIN_EN
    w_op_next_nxt   = r_op_next;
    w_chain_nxt     = r_chain;
`endif
    if (w_key_fire && w_is_ac) begin
      w_a_clear       = 1'b1;
      w_b_clear       = 1'b1;
      w_op_pend_nxt   = ALU_ADD;
      w_b_entered_nxt = 1'b0;
      w_state_nxt     = ST_ENTER_A;
`ifdef CALC_CHAIN_EN
      w_op_next_nxt   = ALU_ADD;
      w_chain_nxt     = 1'b0;
`endif
    end else begin
      case (r_state)
        ST_ENTER_A: begin
          if (w_key_fire && w_is_digit) begin
            w_a_shift = 1'b1;
          end else if (w_key_fire && w_is_op) begin
            w_op_pend_nxt   = w_key_op;
            w_b_clear       = 1'b1;
            w_b_entered_nxt = 1'b0;
            w_state_nxt     = ST_ENTER_B;
          end else begin
            w_state_nxt = r_state;
          end
        end
        ST_ENTER_B: begin
          if (w_key_fire && w_is_digit) begin
            w_b_shift       = 1'b1;
            w_b_entered_nxt = 1'b1;
          end else if (w_key_fire && w_is_op && !r_b_entered) begin
            w_op_pend_nxt = w_key_op;
`ifdef CALC_CHAIN_EN
          end else if (w_key_fire && w_is_op) begin
            w_op_next_nxt = w_key_op;
            w_chain_nxt   = 1'b1;
            w_state_nxt   = ST_ALU_REQ;
`endif
          end else if (w_key_fire && w_is_eq && r_b_entered) begin
            w_state_nxt = ST_ALU_REQ;
          end else begin
            w_state_nxt = r_state;
          end
        end
        ST_ALU_REQ: begin
          if (i_alu_ready) begin
            w_state_nxt = ST_ALU_WAIT;
          end else begin
            w_state_nxt = r_state;
          end
        end
        ST_ALU_WAIT: begin
          if (i_alu_result_valid && i_alu_error) begin
            w_state_nxt = ST_ERROR;
`ifdef CALC_CHAIN_EN
            w_chain_nxt = 1'b0;
`endif
          end else if (i_alu_result_valid) begin
            w_a_load     = 1'b1;
            w_a_load_val = i_alu_result;
`ifdef CALC_CHAIN_EN
            if (r_chain) begin
              w_op_pend_nxt   = r_op_next;
              w_b_clear       = 1'b1;
              w_b_entered_nxt = 1'b0;
              w_chain_nxt     = 1'b0;
              w_state_nxt     = ST_ENTER_B;
            end else begin
              w_state_nxt = ST_SHOW_RESULT;
            end
`else
            w_state_nxt = ST_SHOW_RESULT;
`endif
          end else begin
            w_state_nxt = r_state;
          end
        end
        ST_SHOW_RESULT: begin
          if (w_key_fire && w_is_digit) begin
            w_a_load     = 1'b1;
            w_a_load_val = {{(WIDTH-4){1'b0}}, w_digit};
            w_state_nxt  = ST_ENTER_A;
          end else if (w_key_fire && w_is_op) begin
            w_op_pend_nxt   = w_key_op;
            w_b_clear       = 1'b1;
            w_b_entered_nxt = 1'b0;
            w_state_nxt     = ST_ENTER_B;
          end else if (w_key_fire && w_is_eq) begin
            w_state_nxt = ST_ALU_REQ;
          end else begin
            w_state_nxt = r_state;
          end
        end
        ST_ERROR: begin
          w_state_nxt = r_state;
        end
        default: begin
          w_state_nxt = ST_ENTER_A;
        end
      endcase
    end
  end

  // display source follows the state being entered so it lands one cycle after the event
  always_comb begin
    w_display_nxt = w_a_next;
    case (w_state_nxt)
      ST_ENTER_B: w_display_nxt = w_b_entered_nxt ? w_b_next : w_a_next;
      ST_ERROR:   w_display_nxt = '0;
      default:    w_display_nxt = w_a_next;
    endcase
  end

  // control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_ENTER_A;
      r_op_pend   <= ALU_ADD;
      r_b_entered <= 1'b0;
`ifdef CALC_CHAIN_EN
      r_op_next   <= ALU_ADD;
      r_chain     <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_op_pend   <= w_op_pend_nxt;
      r_b_entered <= w_b_entered_nxt;
`ifdef CALC_CHAIN_EN
      r_op_next   <= w_op_next_nxt;
      r_chain     <= w_chain_nxt;
`endif
    end
  end

  // registered status outputs decoded from the upcoming state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_ready     <= 1'b1;
      r_alu_valid     <= 1'b0;
      r_display_error <= 1'b0;
      r_busy          <= 1'b0;
      r_display_value <= '0;
    end else begin
      r_key_ready     <= (w_state_nxt != ST_ALU_REQ) && (w_state_nxt != ST_ALU_WAIT);
      r_alu_valid     <= (w_state_nxt == ST_ALU_REQ);
      r_display_error <= (w_state_nxt == ST_ERROR);
      r_busy          <= (w_state_nxt == ST_ALU_REQ) || (w_state_nxt == ST_ALU_WAIT);
      r_display_value <= w_display_nxt;
    end
  end

  assign o_key_ready     = r_key_ready;
  assign o_alu_valid     = r_alu_valid;
  assign o_alu_op        = r_op_pend;
  assign o_alu_a         = w_reg_a;
  assign o_alu_b         = w_reg_b;
  assign o_display_value = r_display_value;
  assign o_display_error = r_display_error;
  assign o_busy          = r_busy;

endmodule

// File: tb/tb_calc_controller.sv
// Randomized self-checking bench for calc_controller; the bench also plays the ALU.
// Honours CALC_CHAIN_EN in its reference model when the design is built with it.
module tb_calc_controller;
  import calc_pkg::*;

  localparam int W = 16;
  localparam int M_A = 0, M_B = 1, M_REQ = 2, M_WAIT = 3, M_SHOW = 4, M_ERR = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic [4:0]   i_key_data;
  logic         i_key_valid;
  logic         o_key_ready;
  logic         o_alu_valid;
  logic         i_alu_ready;
  logic [1:0]   o_alu_op;
  logic [W-1:0] o_alu_a, o_alu_b;
  logic         i_alu_result_valid;
  logic [W-1:0] i_alu_result;
  logic         i_alu_error;
  logic [W-1:0] o_display_value;
  logic         o_display_error;
  logic         o_busy;

  always #5 clk = ~clk;

  calc_controller #(.WIDTH(W)) dut (
    .clk                (clk),
    .rst                (rst),
    .i_key_data         (i_key_data),
    .i_key_valid        (i_key_valid),
    .o_key_ready        (o_key_ready),
    .o_alu_valid        (o_alu_valid),
    .i_alu_ready        (i_alu_ready),
    .o_alu_op           (o_alu_op),
    .o_alu_a            (o_alu_a),
    .o_alu_b            (o_alu_b),
    .i_alu_result_valid (i_alu_result_valid),
    .i_alu_result       (i_alu_result),
    .i_alu_error        (i_alu_error),
    .o_display_value    (o_display_value),
    .o_display_error    (o_display_error),
    .o_busy             (o_busy)
  );

  int total = 0;
  int bad   = 0;

  // calculator model state
  int           m_mode;
  logic [W-1:0] m_a, m_b;
  int           m_op, m_opnext;
  bit           m_bent, m_chain;

  logic [W-1:0] req_a, req_b;
  logic [1:0]   req_op;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] shin(input logic [W-1:0] v, input logic [3:0] d);
    if ((v >> (W - 4)) != 0) return v;
    return (v << 4) | W'(d);
  endfunction

  task automatic model_clear();
    m_mode = M_A; m_a = '0; m_b = '0; m_op = 0; m_opnext = 0; m_bent = 0; m_chain = 0;
  endtask

  task automatic model_key(input logic [4:0] k);
    int kv;
    kv = int'(k);
    if (kv == 16) begin
      model_clear();
    end else if (kv < 16) begin
      case (m_mode)
        M_A:    m_a = shin(m_a, k[3:0]);
        M_B:    begin m_b = shin(m_b, k[3:0]); m_bent = 1; end
        M_SHOW: begin m_a = W'(kv); m_mode = M_A; end
        default: ;
      endcase
    end else if (kv >= 17 && kv <= 20) begin
      if (m_mode == M_A || m_mode == M_SHOW) begin
        m_op = kv - 17; m_b = '0; m_bent = 0; m_mode = M_B;
      end else if (m_mode == M_B && !m_bent) begin
        m_op = kv - 17;
`ifdef CALC_CHAIN_EN
      end else if (m_mode == M_B) begin
        m_opnext = kv - 17; m_chain = 1; m_mode = M_REQ;
`endif
      end
    end else if (kv == 21) begin
      if ((m_mode == M_B && m_bent) || m_mode == M_SHOW) m_mode = M_REQ;
    end
  endtask

  task automatic model_result(input logic [W-1:0] res, input bit err);
    if (err) begin
      m_mode = M_ERR; m_chain = 0;
    end else begin
      m_a = res;
      if (m_chain) begin
        m_op = m_opnext; m_b = '0; m_bent = 0; m_chain = 0; m_mode = M_B;
      end else begin
        m_mode = M_SHOW;
      end
    end
  endtask

  function automatic logic [W-1:0] exp_display();
    if (m_mode == M_ERR) return '0;
    if (m_mode == M_B && m_bent) return m_b;
    return m_a;
  endfunction

  task automatic check_status(input string tag);
    check_val({tag, "_disp"}, o_display_value, exp_display());
    check_val({tag, "_err"},  o_display_error, m_mode == M_ERR);
    check_val({tag, "_busy"}, o_busy, m_mode == M_REQ || m_mode == M_WAIT);
    check_val({tag, "_rdy"},  o_key_ready, !(m_mode == M_REQ || m_mode == M_WAIT));
  endtask

  task automatic check_req(input string tag);
    check_val({tag, "_valid"}, o_alu_valid, 1);
    check_val({tag, "_a"},     o_alu_a, m_a);
    check_val({tag, "_b"},     o_alu_b, m_b);
    check_val({tag, "_op"},    o_alu_op, m_op);
    check_status(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_rdy"},   o_key_ready, 1);
    check_val({tag, "_valid"}, o_alu_valid, 0);
    check_val({tag, "_disp"},  o_display_value, 0);
    check_val({tag, "_err"},   o_display_error, 0);
    check_val({tag, "_busy"},  o_busy, 0);
  endtask

  // presents a key from a negedge until consumed, then checks status half a cycle after the edge
  task automatic send_key(input logic [4:0] k);
    bit done;
    done = 0;
    i_key_valid = 1'b1;
    i_key_data  = k;
    for (int n = 0; n < 16 && !done; n++) begin
      if (o_key_ready === 1'b1) done = 1;
      @(posedge clk);
      @(negedge clk);
    end
    i_key_valid = 1'b0;
    check_val("key_consumed", done, 1);
    if (done) model_key(k);
    check_status("key");
  endtask

  task automatic alu_txn(input int dly, input int lat, input bit inj, input bit hold,
                         input logic [4:0] hk);
    logic [W-1:0] res;
    bit           err;
    if (hold) begin
      i_key_valid = 1'b1;
      i_key_data  = hk;
    end
    for (int i = 0; i < dly; i++) begin
      check_req("req_hold");
      i_alu_result_valid = 1'($urandom_range(0, 1));
      i_alu_result       = W'($urandom);
      i_alu_error        = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
    end
    i_alu_result_valid = 1'b0;
    i_alu_error        = 1'b0;
    check_req("req_accept");
    req_a = o_alu_a; req_b = o_alu_b; req_op = o_alu_op;
    i_alu_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_alu_ready = 1'b0;
    m_mode = M_WAIT;
    check_val("valid_after_accept", o_alu_valid, 0);
    check_status("wait");
    for (int i = 1; i < lat; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_val("busy_wait", o_busy, 1);
    end
    err = inj;
    case (m_op)
      0: res = m_a + m_b;
      1: res = m_a - m_b;
      2: res = m_a * m_b;
      default: begin
        if (m_b == 0) begin err = 1; res = '0; end
        else res = m_a / m_b;
      end
    endcase
    if (err) res = W'($urandom);
    i_alu_result_valid = 1'b1;
    i_alu_result       = res;
    i_alu_error        = err;
    @(posedge clk);
    @(negedge clk);
    i_alu_result_valid = 1'b0;
    i_alu_error        = 1'b0;
    i_key_valid        = 1'b0;
    model_result(res, err);
    check_status("result");
    if (hold) send_key(hk);
  endtask

  task automatic press(input logic [4:0] k);
    send_key(k);
    while (m_mode == M_REQ)
      alu_txn($urandom_range(0, 3), $urandom_range(1, 4), $urandom_range(0, 9) == 0, 0, 5'd0);
  endtask

  function automatic logic [4:0] rand_key();
    int r;
    r = $urandom_range(0, 99);
    if (r < 50) return 5'($urandom_range(0, 15));
    if (r < 70) return 5'($urandom_range(17, 20));
    if (r < 85) return KEY_EQ;
    if (r < 90) return KEY_AC;
    return 5'($urandom_range(22, 31));
  endfunction

  initial begin
    rst = 1'b1; i_key_data = 5'd0; i_key_valid = 1'b0; i_alu_ready = 1'b0;
    i_alu_result_valid = 1'b0; i_alu_result = '0; i_alu_error = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // two-digit add with immediate ready and 3-cycle latency
    send_key(5'd1); send_key(5'd2); send_key(KEY_ADD); send_key(5'd3); send_key(KEY_EQ);
    alu_txn(0, 3, 0, 0, 5'd0);
    check_val("t1_a", req_a, 16'h0012);
    check_val("t1_b", req_b, 16'h0003);
    check_val("t1_op", req_op, 2'b00);
    check_val("t1_disp", o_display_value, 16'h0015);
    check_val("t1_busy", o_busy, 0);

    // fifth digit dropped by the overflow guard
    send_key(KEY_AC);
    for (int d = 1; d <= 5; d++) send_key(5'(d));
    check_val("t2_disp", o_display_value, 16'h1234);

    // slow ALU ready with a held key that waits for the result
    send_key(KEY_AC);
    send_key(5'd4); send_key(KEY_ADD); send_key(5'd5); send_key(KEY_EQ);
    alu_txn(5, 2, 0, 1, 5'd7);
    check_val("t3_disp", o_display_value, 16'h0007);

    // divide by zero, digit ignored in error, AC recovers
    send_key(KEY_AC);
    send_key(5'd8); send_key(KEY_DIV); send_key(5'd0); send_key(KEY_EQ);
    alu_txn(1, 2, 0, 0, 5'd0);
    check_val("t4_err", o_display_error, 1);
    check_val("t4_disp", o_display_value, 16'h0000);
    send_key(5'd5);
    check_val("t4_drop", o_display_value, 16'h0000);
    send_key(KEY_AC);
    check_val("t4_clr_err", o_display_error, 0);
    check_val("t4_clr_disp", o_display_value, 16'h0000);

    // repeat-equals reuses op and second operand
    send_key(5'd1); send_key(KEY_ADD); send_key(5'd2); send_key(KEY_EQ);
    alu_txn(0, 1, 0, 0, 5'd0);
    check_val("t5_first", o_display_value, 16'h0003);
    send_key(KEY_EQ);
    alu_txn(2, 2, 0, 0, 5'd0);
    check_val("t5_a", req_a, 16'h0003);
    check_val("t5_b", req_b, 16'h0002);
    check_val("t5_op", req_op, 2'b00);
    check_val("t5_disp", o_display_value, 16'h0005);

    // operator replacement before the second operand
    send_key(KEY_AC);
    send_key(5'd7); send_key(KEY_ADD); send_key(KEY_SUB); send_key(5'd2); send_key(KEY_EQ);
    alu_txn(0, 2, 0, 0, 5'd0);
    check_val("t6_op", req_op, 2'b01);
    check_val("t6_disp", o_display_value, 16'h0005);

`ifdef CALC_CHAIN_EN
    send_key(KEY_AC);
    send_key(5'd2); send_key(KEY_ADD); send_key(5'd3); send_key(KEY_MUL);
    alu_txn(1, 2, 0, 0, 5'd0);
    check_val("chain_first", o_display_value, 16'h0005);
    send_key(5'd4); send_key(KEY_EQ);
    alu_txn(0, 2, 0, 0, 5'd0);
    check_val("chain_op", req_op, 2'b10);
    check_val("chain_disp", o_display_value, 16'h0014);
`endif

    // randomized key stream against the model
    send_key(KEY_AC);
    for (int i = 0; i < 400; i++) press(rand_key());

    // reset while a request is outstanding
    send_key(KEY_AC);
    send_key(5'd1); send_key(KEY_ADD); send_key(5'd1); send_key(KEY_EQ);
    check_val("midrst_valid", o_alu_valid, 1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_clear();
    check_reset_outputs("midrst");
    rst = 1'b0;
    for (int i = 0; i < 40; i++) press(rand_key());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/calc_controller.md
Name: calc_controller

Overview:
Central sequencer of the calculator. Consumes 5-bit key codes from the keypad reader over a valid/ready handshake and builds two operands by hex digit shift-in. It issues arithmetic requests to the shared multi-cycle ALU over a second valid/ready handshake, captures the result or error, and drives the display value.

Parameters:
WIDTH, 16, operand/result width in bits; multiple of 4, minimum 8.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
i_key_data  input  5  key code: 0dddd = hex digit; 10000 AC, 10001 ADD, 10010 SUB, 10011 MUL, 10100 DIV, 10101 EQ; 10110–11111 illegal
i_key_valid  input  1  key code valid
o_key_ready  output  1  controller can accept a key
o_alu_valid  output  1  ALU request valid
i_alu_ready  input  1  ALU accepts request
o_alu_op  output  2  00 add, 01 sub, 10 mul, 11 div
o_alu_a  output  WIDTH  first operand
o_alu_b  output  WIDTH  second operand
i_alu_result_valid  input  1  one-cycle result strobe
i_alu_result  input  WIDTH  result
i_alu_error  input  1  qualifies the result strobe: divide-by-zero or overflow
o_display_value  output  WIDTH  value to display
o_display_error  output  1  error indicator
o_busy  output  1  ALU transaction outstanding

Behaviour:
- Clock clk, single domain; reset rst is synchronous and active-high.
- Reset values:
  - state ENTER_A; reg_a, reg_b, op_pend and b_entered all 0.
  - o_alu_valid=0, o_display_value=0, o_display_error=0, o_busy=0, o_key_ready=1.
- Key handshake:
  - A key is consumed on the cycle i_key_valid && o_key_ready.
  - o_key_ready = 1 in ENTER_A, ENTER_B, SHOW_RESULT and ERROR; 0 in ALU_REQ and ALU_WAIT.
  - Illegal codes are consumed and ignored.
- Digit shift-in: reg <= {reg[WIDTH-5:0], d}. The digit is consumed but dropped if reg[WIDTH-1:WIDTH-4] != 0.
- ENTER_A:
  - digit: shift into reg_a.
  - op: op_pend <= op; reg_b <= 0; b_entered <= 0; go to ENTER_B.
  - EQ: ignored.
  - AC: clear all registers.
- ENTER_B:
  - digit: shift into reg_b; b_entered <= 1.
  - op with b_entered=0: replace op_pend.
  - op with b_entered=1: ignored (see Optional Feature).
  - EQ with b_entered=1: go to ALU_REQ. EQ with b_entered=0: ignored.
  - AC: clear all, go to ENTER_A.
- ALU_REQ:
  - o_alu_valid=1; o_alu_a=reg_a, o_alu_b=reg_b, o_alu_op=op_pend.
  - All four outputs are held stable until i_alu_ready; on that cycle go to ALU_WAIT.
  - i_alu_result_valid is ignored outside ALU_WAIT. The ALU's result latency is ≥1 cycle after accept.
- ALU_WAIT:
  - On i_alu_result_valid with i_alu_error=1: go to ERROR.
  - On i_alu_result_valid with i_alu_error=0: reg_a <= i_alu_result; go to SHOW_RESULT.
- SHOW_RESULT:
  - digit: reg_a <= digit; go to ENTER_A.
  - op: op_pend <= op; reg_b <= 0; b_entered <= 0; go to ENTER_B. reg_a (the result) is the first operand.
  - EQ: go to ALU_REQ with unchanged op_pend and reg_b (repeat-equals).
  - AC: clear all, go to ENTER_A.
- ERROR:
  - AC: clear all, go to ENTER_A.
  - Any other key is consumed and dropped.
- o_display_value:
  - reg_a in ENTER_A, SHOW_RESULT, ALU_REQ and ALU_WAIT.
  - In ENTER_B: reg_b if b_entered, else reg_a.
  - 0 in ERROR.
  - Registered: updates one cycle after the triggering event.
- o_display_error = 1 only in ERROR. o_busy = 1 in ALU_REQ and ALU_WAIT.
- Mid-transaction reset: the transaction is abandoned. The ALU shares rst, so no stale result can arrive.
- Arithmetic semantics (wrap, sign) belong to the ALU; the controller performs no arithmetic.

Optional Feature:
CALC_CHAIN_EN.
- Defined: an op key in ENTER_B with b_entered=1 launches ALU_REQ with op_pend and latches the new op as op_next. On a good result: reg_a <= result, op_pend <= op_next, reg_b <= 0, b_entered <= 0, go to ENTER_B. An error goes to ERROR.
- Undefined: that op key is ignored; op_next logic is absent.

Decomposition:
- Package calc_pkg:
  - key code localparams.
  - alu_op_e enum.
  - ctrl_state_e enum.
  - functions key_is_digit() and key_to_alu_op().
- Sub-module calc_operand_reg: WIDTH-bit shift-in register with clear, parallel load and overflow guard; instantiated for reg_a and reg_b.

Test Plan:
- Keys 1,2,ADD,3,EQ; ALU ready immediately, returns 0x0015 after 3 cycles → request a=0x0012, b=0x0003, op=00; display 0x0015; o_busy low afterward.
- Keys 1,2,3,4,5 → reg_a=0x1234; fifth digit consumed (ready high) and dropped; display 0x1234.
- Request with i_alu_ready low 5 cycles → o_alu_valid, operands and op stable; o_key_ready=0; a held key stays unconsumed until result.
- Keys 8,DIV,0,EQ; ALU returns error → display_error=1, display 0; digit 5 dropped; AC → display 0, error 0, state ENTER_A.
- Keys 1,ADD,2,EQ (result 3), then EQ → second request a=3, b=2, op=00; display 5.
- Keys 7,ADD,SUB,2,EQ → op=01. With CALC_CHAIN_EN, keys 2,ADD,3,MUL,4,EQ → add(2,3)=5, then mul(5,4); display 0x0014.
